// File: rtl/me_engine_pkg.sv
// Shared geometry, types and helpers for the full-search motion-estimation engine.
// Optional build macro used by me_engine: ME_EARLY_TERM_EN.
package me_engine_pkg;

  localparam int BLK     = 16;
  localparam int WIN     = 32;
  localparam int MAX_OFF = 16;

  typedef logic [7:0]  pixel_t;
  typedef logic [63:0] word_t;
  typedef logic [15:0] sad_t;
  typedef logic [4:0]  off_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Search range is symmetric around MAX_OFF/2, so hi = MAX_OFF - lo.
  function automatic off_t range_lo(input logic [1:0] r);
    case (r)
      2'd0:    return off_t'(0);
      2'd1:    return off_t'(4);
      2'd2:    return off_t'(6);
      default: return off_t'(7);
    endcase
  endfunction

  function automatic off_t range_hi(input logic [1:0] r);
    return off_t'(MAX_OFF) - range_lo(r);
  endfunction

  function automatic pixel_t abs_diff(input pixel_t a, input pixel_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/me_row_sad.sv
// Combinational sum of absolute differences over one 16-pixel row pair.
module me_row_sad
  import me_engine_pkg::*;
(
  input  logic [BLK*8-1:0] cur_row,
  input  logic [BLK*8-1:0] ref_row,
  output logic [11:0]      row_sad
);

  always_comb begin
    row_sad = '0;
    for (int x = 0; x < BLK; x++) begin
      row_sad = row_sad + 12'(abs_diff(cur_row[8*x +: 8], ref_row[8*x +: 8]));
    end
  end

endmodule

// File: rtl/me_engine.sv
// Full-search block-matching motion estimator: one row SAD per cycle, raster scan.
// Define ME_EARLY_TERM_EN to abandon a candidate once its partial SAD reaches the best.
// Handshake: go is a request accepted in IDLE or DONE (ignored in SEARCH); done is a
// level that holds m_i/m_j valid until the next accepted go or reset.
module me_engine
  import me_engine_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_write,
  input  logic        clk_read,
  input  logic [1:0]  r,
  input  logic        go,
  input  logic [6:0]  address_write_ref,
  input  word_t       data_write_ref,
  input  logic        write_enable_ref,
  input  logic [4:0]  address_write_cur,
  input  word_t       data_write_cur,
  input  logic        write_enable_cur,
  output logic [7:0]  m_i,
  output logic [7:0]  m_j,
  output logic        done,
  output state_t      dbg_state
);

  word_t ref_mem [128];
  word_t cur_mem [32];

  state_t     state;
  off_t       ci, cj, lo, hi, best_i, best_j;
  logic [3:0] cy;
  sad_t       acc, best;

  word_t ref_q0, ref_q1, ref_q2, cur_q0, cur_q1;

  logic [11:0]      row_sad;
  logic [BLK*8-1:0] ref_row;
  sad_t             partial;
  logic             last_row, abort, cand_end, last_cand, better;
  off_t             ni, nj, go_lo, ref_row_n;
  logic [3:0]       ny;
  logic [1:0]       w0, w1, w2;

  assign dbg_state = state;
  assign go_lo     = range_lo(r);

  always_ff @(posedge clk_write) begin
    if (write_enable_ref) ref_mem[address_write_ref] <= data_write_ref;
    if (write_enable_cur) cur_mem[address_write_cur] <= data_write_cur;
  end

  // Next-row counters drive the registered reads, so the row used in a SEARCH
  // cycle was fetched on the preceding edge.
  always_comb begin
    partial   = acc + sad_t'(row_sad);
    last_row  = (cy == 4'd15);
`ifdef ME_EARLY_TERM_EN
    abort     = (partial >= best);
`else
    abort     = 1'b0;
`endif
    cand_end  = last_row | abort;
    better    = last_row && (partial < best);
    last_cand = (ci == hi) && (cj == hi);
    ni        = ci;
    nj        = cj;
    ny        = cy + 4'd1;
    if (state != SEARCH) begin
      ni = go_lo;
      nj = go_lo;
      ny = 4'd0;
    end else if (cand_end) begin
      ny = 4'd0;
      if (cj == hi) begin
        nj = lo;
        ni = ci + off_t'(1);
      end else begin
        nj = cj + off_t'(1);
      end
    end
    ref_row_n = ni + off_t'(ny);
    w0        = nj[4:3];
    w1        = w0 + 2'd1;
    w2        = (w0 == 2'd2) ? 2'd3 : w0 + 2'd2;
  end

  always_ff @(posedge clk_read) begin
    ref_q0 <= ref_mem[{ref_row_n, w0}];
    ref_q1 <= ref_mem[{ref_row_n, w1}];
    ref_q2 <= ref_mem[{ref_row_n, w2}];
    cur_q0 <= cur_mem[{ny, 1'b0}];
    cur_q1 <= cur_mem[{ny, 1'b1}];
  end

  // Unaligned 16-pixel span: up to three words, shifted down by j mod 8 pixels.
  assign ref_row = 128'({ref_q2, ref_q1, ref_q0} >> {cj[2:0], 3'b000});

  me_row_sad u_row_sad (
    .cur_row (cur_row_w()),
    .ref_row (ref_row),
    .row_sad (row_sad)
  );

  function automatic logic [BLK*8-1:0] cur_row_w();
    return {cur_q1, cur_q0};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      m_i    <= 8'd0;
      m_j    <= 8'd0;
      ci     <= '0;
      cj     <= '0;
      cy     <= '0;
      lo     <= '0;
      hi     <= '0;
      acc    <= '0;
      best   <= '1;
      best_i <= '0;
      best_j <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            state <= SEARCH;
            done  <= 1'b0;
            lo    <= go_lo;
            hi    <= range_hi(r);
            ci    <= go_lo;
            cj    <= go_lo;
            cy    <= 4'd0;
            acc   <= '0;
            best  <= '1;
          end
        end
        SEARCH: begin
          acc <= cand_end ? sad_t'(0) : partial;
          ci  <= ni;
          cj  <= nj;
          cy  <= ny;
          if (better) begin
            best   <= partial;
            best_i <= ci;
            best_j <= cj;
          end
          if (cand_end && last_cand) begin
            state <= DONE;
            done  <= 1'b1;
            m_i   <= 8'(better ? ci : best_i);
            m_j   <= 8'(better ? cj : best_j);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_engine.sv
// Directed and random-vector bench for me_engine with a software SAD model.
module tb_me_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  r;
  logic        go;
  logic [6:0]  address_write_ref;
  logic [63:0] data_write_ref;
  logic        write_enable_ref;
  logic [4:0]  address_write_cur;
  logic [63:0] data_write_cur;
  logic        write_enable_cur;
  logic [7:0]  m_i, m_j;
  logic        done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_px [32][32];
  logic [7:0]  cur_px [16][16];
  logic [15:0] exp_q [$];

  me_engine dut (
    .clk               (clk),
    .reset             (reset),
    .clk_write         (clk),
    .clk_read          (clk),
    .r                 (r),
    .go                (go),
    .address_write_ref (address_write_ref),
    .data_write_ref    (data_write_ref),
    .write_enable_ref  (write_enable_ref),
    .address_write_cur (address_write_cur),
    .data_write_cur    (data_write_cur),
    .write_enable_cur  (write_enable_cur),
    .m_i               (m_i),
    .m_j               (m_j),
    .done              (done),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic int lo_of(input logic [1:0] rr);
    case (rr)
      2'd0:    return 0;
      2'd1:    return 4;
      2'd2:    return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [15:0] model_best(input logic [1:0] rr);
    int lo, hi, best, bi, bj, sad, d;
    lo = lo_of(rr);
    hi = 16 - lo;
    best = 1 << 30;
    bi = 0;
    bj = 0;
    for (int i = lo; i <= hi; i++) begin
      for (int j = lo; j <= hi; j++) begin
        sad = 0;
        for (int y = 0; y < 16; y++) begin
          for (int x = 0; x < 16; x++) begin
            d = int'(cur_px[y][x]) - int'(ref_px[y+i][x+j]);
            sad += (d < 0) ? -d : d;
          end
        end
        if (sad < best) begin
          best = sad;
          bi = i;
          bj = j;
        end
      end
    end
    return {8'(bi), 8'(bj)};
  endfunction

  // ---------------- pattern helpers ----------------
  task automatic fill_ref(input logic [7:0] v);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) ref_px[y][x] = v;
  endtask

  task automatic make_cur(input int mode);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        case (mode)
          0:       cur_px[y][x] = 8'((y * 8 + x) & 8'h7F);
          1:       cur_px[y][x] = 8'((y * 16 + x * 3 + 17) & 8'h7F);
          default: cur_px[y][x] = 8'((x * 11 + y * 5) & 8'h7F);
        endcase
      end
  endtask

  task automatic place(input int bi, input int bj);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) ref_px[bi+y][bj+x] = cur_px[y][x];
  endtask

  // ---------------- drivers ----------------
  task automatic load_mem();
    logic [63:0] d;
    @(negedge clk);
    for (int row = 0; row < 32; row++)
      for (int w = 0; w < 4; w++) begin
        for (int k = 0; k < 8; k++) d[8*k +: 8] = ref_px[row][w*8+k];
        address_write_ref = 7'(row * 4 + w);
        data_write_ref    = d;
        write_enable_ref  = 1'b1;
        @(negedge clk);
      end
    write_enable_ref = 1'b0;
    for (int row = 0; row < 16; row++)
      for (int w = 0; w < 2; w++) begin
        for (int k = 0; k < 8; k++) d[8*k +: 8] = cur_px[row][w*8+k];
        address_write_cur = 5'(row * 2 + w);
        data_write_cur    = d;
        write_enable_cur  = 1'b1;
        @(negedge clk);
      end
    write_enable_cur = 1'b0;
  endtask

  task automatic run_search(input logic [1:0] rr, input string tag);
    int n, bound, cnt;
    logic [15:0] e;
    n = 17 - 2 * lo_of(rr);
    bound = n * n * 16 + 8;
    @(negedge clk);
    r  = rr;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    check({tag, ".done_drop"}, 32'(done), 32'd0);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!done && cnt < 6000);
    check({tag, ".latency_ok"}, 32'(cnt <= bound), 32'd1);
    e = exp_q.pop_front();
    check({tag, ".m_i"}, 32'(m_i), 32'(e[15:8]));
    check({tag, ".m_j"}, 32'(m_j), 32'(e[7:0]));
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".held"}, {23'd0, done, m_i}, {23'd0, 1'b1, e[15:8]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    go = 1'b0;
    r = 2'd0;
    address_write_ref = '0;
    data_write_ref = '0;
    write_enable_ref = 1'b0;
    address_write_cur = '0;
    data_write_cur = '0;
    write_enable_cur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.done", 32'(done), 32'd0);
    check("reset.m_i", 32'(m_i), 32'd0);
    check("reset.m_j", 32'(m_j), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Block copied at (5,11) over a 0xFF window
    fill_ref(8'hFF);
    make_cur(0);
    place(5, 11);
    load_mem();
    exp_q.push_back({8'd5, 8'd11});
    run_search(2'd0, "blk_5_11");

    // Flat image: every SAD is zero, first candidate wins
    fill_ref(8'h42);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) cur_px[y][x] = 8'h42;
    load_mem();
    exp_q.push_back({8'd0, 8'd0});
    run_search(2'd0, "flat_r0");
    exp_q.push_back({8'd6, 8'd6});
    run_search(2'd2, "flat_r2");

    // Block at the far corner, full range then restricted range
    fill_ref(8'hFF);
    make_cur(1);
    place(16, 16);
    load_mem();
    exp_q.push_back({8'd16, 8'd16});
    run_search(2'd0, "blk_16_16");
    exp_q.push_back(model_best(2'd1));
    run_search(2'd1, "blk_16_16_r1");

    // Reset 100 cycles into a search
    @(negedge clk);
    r  = 2'd0;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.m_i", 32'(m_i), 32'd0);
    check("midrst.m_j", 32'(m_j), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fill_ref(8'hFF);
    make_cur(0);
    place(5, 11);
    load_mem();
    exp_q.push_back({8'd5, 8'd11});
    run_search(2'd0, "after_rst");

    // Back-to-back searches restarted from DONE
    fill_ref(8'hFF);
    make_cur(2);
    place(5, 7);
    load_mem();
    exp_q.push_back({8'd5, 8'd7});
    run_search(2'd1, "b2b_a");
    fill_ref(8'hFF);
    make_cur(1);
    place(9, 12);
    load_mem();
    exp_q.push_back({8'd9, 8'd12});
    run_search(2'd1, "b2b_b");

    // Random memories against the software model
    for (int t = 0; t < 50; t++) begin
      logic [1:0] rr;
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++) ref_px[y][x] = 8'($urandom_range(0, 255));
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) cur_px[y][x] = 8'($urandom_range(0, 255));
      rr = 2'($urandom_range(1, 3));
      load_mem();
      exp_q.push_back(model_best(rr));
      run_search(rr, $sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
